// File: rtl/tm_update_ctrl.sv
// Transaction-monitor update controller: times transactions, queues their lengths and
// serialises running-average updates through the external TM_ALU. Option: TM_DROP_CNT_EN.
module tm_update_ctrl #(
  parameter int WIDTH_OF_TXLEN = 8,
  parameter int WIDTH_OF_EXED  = 8,
  parameter int ALU_LATENCY    = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tx_begin,
  input  logic                      tx_end,
  output logic [WIDTH_OF_TXLEN-1:0] alu_avg,
  output logic [WIDTH_OF_EXED-1:0]  alu_exed,
  output logic [WIDTH_OF_TXLEN-1:0] alu_cur,
  input  logic [WIDTH_OF_TXLEN-1:0] alu_avg_new,
  input  logic [WIDTH_OF_EXED-1:0]  alu_exed_new,
  output logic [WIDTH_OF_TXLEN-1:0] avg_tx_len,
  output logic [WIDTH_OF_EXED-1:0]  inst_exed,
  output logic                      busy,
  output logic                      saturated,
  output logic [7:0]                drop_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(ALU_LATENCY + 1);
  localparam logic [WIDTH_OF_TXLEN-1:0] LEN_ONE = WIDTH_OF_TXLEN'(1);
  localparam logic [WIDTH_OF_TXLEN-1:0] LEN_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPT} state_t;

  state_t                    state_q, state_d;
  logic                      armed_q, armed_d;
  logic [WIDTH_OF_TXLEN-1:0] len_q, len_d, len_inc, push_len;
  logic                      push, push_ok, pop, issue, capture;
  logic [WIDTH_OF_TXLEN-1:0] fifo_q [FIFO_DEPTH];
  logic [AW:0]               wr_q, rd_q;
  logic                      empty, full;
  logic [WIDTH_OF_TXLEN-1:0] head;
  logic [CW-1:0]             cnt_q;
  logic [WIDTH_OF_TXLEN-1:0] alu_avg_q, alu_cur_q, avg_q;
  logic [WIDTH_OF_EXED-1:0]  alu_exed_q, exed_q;

  // Length counter: the pushed length counts both the begin and the end cycle.
  assign len_inc = (len_q == LEN_MAX) ? LEN_MAX : len_q + LEN_ONE;

  always_comb begin
    armed_d  = armed_q;
    len_d    = len_q;
    push     = 1'b0;
    push_len = armed_q ? len_inc : LEN_ONE;
    if (tx_end && (armed_q || tx_begin)) push = 1'b1;
    if (tx_begin) begin
      armed_d = !tx_end || armed_q;
      len_d   = LEN_ONE;
    end else if (tx_end) begin
      armed_d = 1'b0;
    end else if (armed_q) begin
      len_d = len_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q <= 1'b0;
      len_q   <= '0;
    end else begin
      armed_q <= armed_d;
      len_q   <= len_d;
    end
  end

  // Pending-length FIFO; a full FIFO still accepts a push when it is popped that cycle.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head    = fifo_q[rd_q[AW-1:0]];
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_q[AW-1:0]] <= push_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!empty && !saturated) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == CW'(1)) state_d = S_CAPT;
      S_CAPT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A saturated count freezes the statistics, so queued lengths are drained unused.
  always_comb begin
    pop     = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        pop   = !empty;
        issue = !empty && !saturated;
      end
      S_WAIT:  ;
      S_CAPT:  capture = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_avg_q  <= '0;
      alu_exed_q <= '0;
      alu_cur_q  <= '0;
      cnt_q      <= '0;
      avg_q      <= '0;
      exed_q     <= '0;
    end else begin
      if (issue) begin
        alu_avg_q  <= avg_q;
        alu_exed_q <= exed_q;
        alu_cur_q  <= head;
        cnt_q      <= CW'(ALU_LATENCY);
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (capture) begin
        avg_q  <= alu_avg_new;
        exed_q <= alu_exed_new;
      end
    end
  end

`ifdef TM_DROP_CNT_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   drop_q <= '0;
    else if (push && !push_ok && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'd0;
`endif

  assign alu_avg    = alu_avg_q;
  assign alu_exed   = alu_exed_q;
  assign alu_cur    = alu_cur_q;
  assign avg_tx_len = avg_q;
  assign inst_exed  = exed_q;
  assign busy       = (state_q != S_IDLE);
  assign saturated  = (exed_q == '1);

endmodule

// File: tb/tb_tm_update_ctrl.sv
// Directed bench for tm_update_ctrl with a pipelined running-average ALU model and a
// scoreboard of expected issued lengths.
module tb_tm_update_ctrl;
  localparam int W   = 8;
  localparam int E   = 8;
  localparam int LAT = 4;
  localparam int D   = 4;

  logic         clk = 1'b0, reset = 1'b1, tx_begin = 1'b0, tx_end = 1'b0;
  logic [W-1:0] alu_avg, alu_cur, alu_avg_new, avg_tx_len;
  logic [E-1:0] alu_exed, alu_exed_new, inst_exed;
  logic         busy, saturated;
  logic [7:0]   drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] sbq[$];

  tm_update_ctrl #(.WIDTH_OF_TXLEN(W), .WIDTH_OF_EXED(E), .ALU_LATENCY(LAT), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .tx_begin(tx_begin), .tx_end(tx_end),
    .alu_avg(alu_avg), .alu_exed(alu_exed), .alu_cur(alu_cur),
    .alu_avg_new(alu_avg_new), .alu_exed_new(alu_exed_new),
    .avg_tx_len(avg_tx_len), .inst_exed(inst_exed), .busy(busy),
    .saturated(saturated), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] avg_calc(logic [31:0] a, logic [31:0] e, logic [31:0] c);
    return (a * e + c) / (e + 1);
  endfunction

  // ALU model: result appears LAT rising edges after the operands are presented.
  logic [W-1:0] p_avg  [LAT];
  logic [E-1:0] p_exed [LAT];
  always @(posedge clk) begin
    p_avg[0]  <= W'(avg_calc(32'(alu_avg), 32'(alu_exed), 32'(alu_cur)));
    p_exed[0] <= alu_exed + 1'b1;
    for (int i = 1; i < LAT; i++) begin
      p_avg[i]  <= p_avg[i-1];
      p_exed[i] <= p_exed[i-1];
    end
  end
  assign alu_avg_new  = p_avg[LAT-1];
  assign alu_exed_new = p_exed[LAT-1];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: operands at issue, result and busy length at capture, stability otherwise.
  logic        busy_p = 1'b0;
  int          bcnt = 0;
  logic [31:0] m_avg = 0, m_exed = 0, i_cur = 0;
  always @(posedge clk) begin
    #1;
    if (reset) begin
      busy_p = 1'b0;
      m_avg  = 0;
      m_exed = 0;
      bcnt   = 0;
    end else begin
      if (busy && !busy_p) begin
        chk("sb_nonempty_at_issue", 32'(sbq.size() > 0), 1);
        i_cur = (sbq.size() > 0) ? sbq.pop_front() : 32'hFFFF_FFFF;
        chk("issue_alu_cur", 32'(alu_cur), i_cur);
        chk("issue_alu_avg", 32'(alu_avg), m_avg);
        chk("issue_alu_exed", 32'(alu_exed), m_exed);
        bcnt = 0;
      end
      if (busy) bcnt++;
      if (!busy && busy_p) begin
        m_avg  = avg_calc(m_avg, m_exed, i_cur) & 32'hFF;
        m_exed = (m_exed + 1) & 32'hFF;
        chk("busy_cycles", 32'(bcnt), LAT + 1);
      end
      chk("avg_tx_len", 32'(avg_tx_len), m_avg);
      chk("inst_exed", 32'(inst_exed), m_exed);
      chk("saturated", 32'(saturated), 32'(m_exed == 255));
      busy_p = busy;
    end
  end

  task automatic step(logic b, logic e);
    tx_begin = b;
    tx_end   = e;
    @(negedge clk);
  endtask

  task automatic tx(int len);
    if (len == 1) step(1'b1, 1'b1);
    else begin
      step(1'b1, 1'b0);
      repeat (len - 2) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
    end
    tx_begin = 1'b0;
    tx_end   = 1'b0;
  endtask

  task automatic do_reset();
    tx_begin = 1'b0;
    tx_end   = 1'b0;
    reset    = 1'b1;
    sbq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(string tag);
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(n < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_avg", 32'(avg_tx_len), 0);
    chk("rst_exed", 32'(inst_exed), 0);
    chk("rst_alu_cur", 32'(alu_cur), 0);
    chk("rst_sat", 32'(saturated), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single 10-cycle transaction, then 20 and 31 spaced apart.
    sbq.push_back(10); tx(10); wait_drain("t10");
    chk("t10_avg", 32'(avg_tx_len), 10);
    chk("t10_exed", 32'(inst_exed), 1);
    repeat (20) @(negedge clk);
    sbq.push_back(20); tx(20); wait_drain("t20");
    chk("t20_avg", 32'(avg_tx_len), 15);
    chk("t20_exed", 32'(inst_exed), 2);
    repeat (20) @(negedge clk);
    sbq.push_back(31); tx(31); wait_drain("t31");
    chk("t31_avg", 32'(avg_tx_len), 20);
    chk("t31_exed", 32'(inst_exed), 3);

    // Six back-to-back length-1 pushes: five accepted, one dropped.
    do_reset();
    for (int i = 0; i < 5; i++) sbq.push_back(1);
    repeat (6) step(1'b1, 1'b1);
    tx_begin = 1'b0; tx_end = 1'b0;
    wait_drain("burst");
    chk("burst_exed", 32'(inst_exed), 5);
    chk("burst_avg", 32'(avg_tx_len), 1);
`ifdef TM_DROP_CNT_EN
    chk("burst_drop", 32'(drop_cnt), 1);
`else
    chk("burst_drop", 32'(drop_cnt), 0);
`endif

    // Over-long transaction saturates the measured length.
    do_reset();
    sbq.push_back(255); tx(300); wait_drain("t300");
    chk("t300_avg", 32'(avg_tx_len), 255);
    chk("t300_exed", 32'(inst_exed), 1);

    // Reset during WAIT with a second length still queued.
    do_reset();
    sbq.push_back(3); tx(3);
    sbq.push_back(3); tx(3);
    chk("mid_busy_before", 32'(busy), 1);
    #2 reset = 1'b1;
    sbq.delete();
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_alu_avg", 32'(alu_avg), 0);
    chk("mid_alu_exed", 32'(alu_exed), 0);
    chk("mid_alu_cur", 32'(alu_cur), 0);
    chk("mid_avg", 32'(avg_tx_len), 0);
    chk("mid_exed", 32'(inst_exed), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("mid_after_busy", 32'(busy), 0);
    chk("mid_after_exed", 32'(inst_exed), 0);

    // 255 updates of length 7 reach saturation; a further length is discarded.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      sbq.push_back(7);
      tx(7);
    end
    wait_drain("sat");
    chk("sat_exed", 32'(inst_exed), 255);
    chk("sat_avg", 32'(avg_tx_len), 7);
    chk("sat_flag", 32'(saturated), 1);
    tx(7);
    repeat (20) @(negedge clk);
    chk("sat_after_busy", 32'(busy), 0);
    chk("sat_after_exed", 32'(inst_exed), 255);
    chk("sat_after_avg", 32'(avg_tx_len), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
